// File: rtl/ad_ip_jesd204_tpl_adc_pn_checker.sv
// -----------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_pn_checker
//
// Per-channel PN9 / PN23 / ramp sequence monitor for the JESD204 TPL ADC data
// path. Runs entirely in the link_clk domain. Each beat is compared against
// the expectation built from the previous valid beat. Runs of matches and
// mismatches move the checker into and out of sync.
//
// Ports:
//   link_clk      data-path clock
//   adc_rst       synchronous active-high reset
//   adc_valid     beat qualifier; the checker only advances on valid beats
//   adc_data      DATA_PATH_WIDTH samples, sample 0 (earliest) in the LSBs
//   pn_seq_sel    0 = PN9, 1 = PN23, 2 = ramp, anything else = disabled
//   pn_err        one-cycle pulse per mismatching beat while in sync
//   pn_oos        high while out of sync
//   pn_err_count  saturating count of pn_err pulses (optional, see below)
//
// Optional feature: define AD_IP_JESD204_TPL_PN_ERR_COUNT_EN to add the
// pn_err_count output. The count is cleared by reset and by a pn_seq_sel
// change, and has the same latency as pn_err.
//
// Timing: a beat is registered in stage 1 and compared in stage 2, so
// pn_err and pn_oos respond two cycles after the beat is presented.
// -----------------------------------------------------------------------------
module ad_ip_jesd204_tpl_adc_pn_checker #(
  parameter int DATA_PATH_WIDTH      = 1,
  parameter int CONVERTER_RESOLUTION = 16,
  parameter int OOS_THRESHOLD        = 16
) (
  input  logic                                            link_clk,
  input  logic                                            adc_rst,
  input  logic                                            adc_valid,
  input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] adc_data,
  input  logic [3:0]                                      pn_seq_sel,
  output logic                                            pn_err,
  output logic                                            pn_oos
`ifdef AD_IP_JESD204_TPL_PN_ERR_COUNT_EN
  ,
  output logic [31:0]                                     pn_err_count
`endif
);

  localparam int RES  = CONVERTER_RESOLUTION;
  localparam int DW   = DATA_PATH_WIDTH * CONVERTER_RESOLUTION;
  localparam int HIST = 23;  // longest LFSR history needed (PN23)
  localparam logic [7:0] THR = 8'(OOS_THRESHOLD);

  typedef enum logic [1:0] {
    MODE_PN9,
    MODE_PN23,
    MODE_RAMP,
    MODE_OFF
  } mode_e;

  typedef enum logic {
    ST_OOS,
    ST_SYNC
  } state_e;

  // Stream bit s (0 = first bit on the wire) lives in sample s/RES, and
  // samples are sent MSB first.
  function automatic int stream_pos(input int s);
    return (s / RES) * RES + (RES - 1) - (s % RES);
  endfunction

  // Stage 1
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;

  // Stage 2
  logic [DW-1:0] prev_q, prev_d;
  logic          seeded_q, seeded_d;
  logic [3:0]    sel_q, sel_d;
  state_e        state_q, state_d;
  logic [7:0]    match_cnt_q, match_cnt_d;
  logic [7:0]    mis_cnt_q, mis_cnt_d;
  logic          pn_err_q, pn_err_d;
  logic          pn_oos_q, pn_oos_d;

  mode_e         mode;
  logic          sel_chg;
  logic [DW-1:0] exp_pn;
  logic [DW-1:0] exp_ramp;
  logic [DW-1:0] exp_beat;
  logic          beat_match;

  // Mode is taken from the registered select. On a select change the stage
  // is cleared anyway, so the one-cycle lag never reaches a comparison.
  always_comb begin
    case (sel_q)
      4'd0:    mode = MODE_PN9;
      4'd1:    mode = MODE_PN23;
      4'd2:    mode = MODE_RAMP;
      default: mode = MODE_OFF;
    endcase
  end

  assign sel_chg = (pn_seq_sel != sel_q);

  // LFSR expectation: the last HIST stream bits of the previous beat form
  // the seed, then the recurrence runs for DW more bits. PN9 only looks
  // back 9 bits, so it reads the tail of the same seed window.
  always_comb begin : gen_pn
    logic [DW+HIST-1:0] bits;
    bits = '0;
    for (int i = 0; i < HIST; i++) begin
      bits[i] = prev_q[stream_pos(DW - HIST + i)];
    end
    for (int i = HIST; i < DW + HIST; i++) begin
      if (mode == MODE_PN23) begin
        bits[i] = bits[i-23] ^ bits[i-18];
      end else begin
        bits[i] = bits[i-9] ^ bits[i-5];
      end
    end
    exp_pn = '0;
    for (int i = 0; i < DW; i++) begin
      exp_pn[stream_pos(i)] = bits[HIST + i];
    end
  end

  // Ramp expectation: each sample is the previous beat's last sample plus
  // its distance from it, wrapping naturally at RES bits.
  always_comb begin : gen_ramp
    logic [RES-1:0] last;
    last     = prev_q[DW-1 -: RES];
    exp_ramp = '0;
    for (int k = 0; k < DATA_PATH_WIDTH; k++) begin
      exp_ramp[k*RES +: RES] = last + RES'(k + 1);
    end
  end

  assign exp_beat = (mode == MODE_RAMP) ? exp_ramp : exp_pn;

  // An all-zero beat would lock a PN LFSR up, so it never counts as a match.
  assign beat_match = (data_q == exp_beat) &&
                      ((mode == MODE_RAMP) || (data_q != '0));

  always_comb begin
    // NOTE: every _d signal takes its held value first so that no path
    // through this block leaves a signal unassigned, which would infer a latch.
    valid_d     = adc_valid;
    data_d      = adc_valid ? adc_data : data_q;
    prev_d      = prev_q;
    seeded_d    = seeded_q;
    sel_d       = pn_seq_sel;
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    mis_cnt_d   = mis_cnt_q;
    pn_err_d    = 1'b0;

    if (sel_chg || (mode == MODE_OFF)) begin
      // A new select restarts seeding and drops any pulse that was about
      // to be raised for the old sequence.
      state_d     = ST_OOS;
      match_cnt_d = '0;
      mis_cnt_d   = '0;
      seeded_d    = 1'b0;
    end else if (valid_q) begin
      prev_d   = data_q;
      seeded_d = 1'b1;
      if (seeded_q) begin
        case (state_q)
          ST_OOS: begin
            if (!beat_match) begin
              match_cnt_d = '0;
            end else if (match_cnt_q + 8'd1 >= THR) begin
              state_d     = ST_SYNC;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + 8'd1;
            end
          end
          ST_SYNC: begin
            if (beat_match) begin
              mis_cnt_d = '0;
            end else begin
              pn_err_d = 1'b1;
              if (mis_cnt_q + 8'd1 >= THR) begin
                state_d   = ST_OOS;
                mis_cnt_d = '0;
              end else begin
                mis_cnt_d = mis_cnt_q + 8'd1;
              end
            end
          end
          default: state_d = ST_OOS;
        endcase
      end
    end

    pn_oos_d = (state_d == ST_OOS);
  end

  always_ff @(posedge link_clk) begin
    if (adc_rst) begin
      // NOTE: the sample registers are reset as well, not just the control
      // state, so that a stale beat can never seed the first comparison.
      data_q      <= '0;
      valid_q     <= 1'b0;
      prev_q      <= '0;
      seeded_q    <= 1'b0;
      sel_q       <= pn_seq_sel;
      state_q     <= ST_OOS;
      match_cnt_q <= '0;
      mis_cnt_q   <= '0;
      pn_err_q    <= 1'b0;
      pn_oos_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      data_q      <= data_d;
      valid_q     <= valid_d;
      prev_q      <= prev_d;
      seeded_q    <= seeded_d;
      sel_q       <= sel_d;
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
      pn_err_q    <= pn_err_d;
      pn_oos_q    <= pn_oos_d;
    end
  end

  assign pn_err = pn_err_q;
  assign pn_oos = pn_oos_q;

`ifdef AD_IP_JESD204_TPL_PN_ERR_COUNT_EN
  logic [31:0] err_cnt_q, err_cnt_d;

  // Saturating error count; a sync-state transition does not clear it.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (sel_chg) begin
      err_cnt_d = '0;
    end else if (pn_err_d && (err_cnt_q != 32'hFFFF_FFFF)) begin
      err_cnt_d = err_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge link_clk) begin
    if (adc_rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pn_err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pn_checker.sv
// -----------------------------------------------------------------------------
// Testbench for ad_ip_jesd204_tpl_adc_pn_checker (DPW=2, RES=16, THR=16).
// A behavioural model tracks the stream at bit level with a queue and keeps
// sync status as a single run length. Every cycle the DUT outputs are compared
// against it, and directed checks pin down latencies and pulse counts.
// -----------------------------------------------------------------------------
module tb_ad_ip_jesd204_tpl_adc_pn_checker;

  localparam int DPW = 2;
  localparam int RES = 16;
  localparam int THR = 16;
  localparam int N   = DPW * RES;

  logic         link_clk = 1'b0;
  logic         adc_rst;
  logic         adc_valid;
  logic [N-1:0] adc_data;
  logic [3:0]   pn_seq_sel;
  logic         pn_err;
  logic         pn_oos;
`ifdef AD_IP_JESD204_TPL_PN_ERR_COUNT_EN
  logic [31:0]  pn_err_count;
`endif

  always #5 link_clk = ~link_clk;

  ad_ip_jesd204_tpl_adc_pn_checker #(
    .DATA_PATH_WIDTH      (DPW),
    .CONVERTER_RESOLUTION (RES),
    .OOS_THRESHOLD        (THR)
  ) dut (
    .link_clk     (link_clk),
    .adc_rst      (adc_rst),
    .adc_valid    (adc_valid),
    .adc_data     (adc_data),
    .pn_seq_sel   (pn_seq_sel),
    .pn_err       (pn_err),
    .pn_oos       (pn_oos)
`ifdef AD_IP_JESD204_TPL_PN_ERR_COUNT_EN
    ,
    .pn_err_count (pn_err_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen;
  int event_at;

  // Reference model state
  logic [N-1:0] m_pend;
  bit           m_pend_v;
  logic [N-1:0] m_prev;
  bit           m_seeded;
  bit           m_sync;
  int           m_run;
  logic [3:0]   m_sel;
  bit           m_err;
  bit           m_oos;
  logic [31:0]  m_cnt;

  logic [N-1:0] gen;
  logic [15:0]  ramp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next beat of a sequence, from the rules: PN bits continue the recurrence
  // over the serial stream; ramp samples keep counting from the last sample.
  function automatic logic [N-1:0] next_beat(input logic [N-1:0] prev, input logic [3:0] sel);
    logic [N-1:0] r;
    logic [15:0]  last;
    bit           q[$];
    r = '0;
    if (sel == 4'd2) begin
      last = prev[N-1 -: 16];
      for (int k = 0; k < DPW; k++) r[k*16 +: 16] = last + 16'(k + 1);
    end else begin
      for (int s = 0; s < N; s++) q.push_back(prev[(s / RES) * RES + RES - 1 - s % RES]);
      for (int s = 0; s < N; s++) begin
        int l;
        l = q.size();
        if (sel == 4'd1) q.push_back(q[l-23] ^ q[l-18]);
        else             q.push_back(q[l-9] ^ q[l-5]);
      end
      for (int s = 0; s < N; s++) r[(s / RES) * RES + RES - 1 - s % RES] = q[N + s];
    end
    return r;
  endfunction

  // Model update for one clock edge, using the inputs in force at that edge.
  task automatic model_edge();
    bit ok;
    if (adc_rst) begin
      m_pend_v = 0; m_pend = '0; m_prev = '0; m_seeded = 0;
      m_sync = 0; m_run = 0; m_sel = pn_seq_sel; m_err = 0; m_cnt = '0;
    end else begin
      m_err = 0;
      if (pn_seq_sel != m_sel) begin
        m_sync = 0; m_run = 0; m_seeded = 0; m_cnt = '0;
        m_sel = pn_seq_sel;
      end else if (m_sel > 4'd2) begin
        m_sync = 0; m_run = 0; m_seeded = 0;
      end else if (m_pend_v) begin
        if (m_seeded) begin
          ok = (m_pend == next_beat(m_prev, m_sel)) && !(m_sel != 4'd2 && m_pend == '0);
          if (!m_sync) begin
            m_run = ok ? m_run + 1 : 0;
            if (m_run == THR) begin m_sync = 1; m_run = 0; end
          end else if (ok) begin
            m_run = 0;
          end else begin
            m_err = 1;
            m_run++;
            if (m_run == THR) begin m_sync = 0; m_run = 0; end
          end
        end
        m_seeded = 1;
        m_prev   = m_pend;
      end
      if (m_err && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      m_pend_v = adc_valid;
      if (adc_valid) m_pend = adc_data;
    end
    m_oos = !m_sync;
  endtask

  // One clock: drive a beat, let the edge pass, compare outputs to the model.
  task automatic tick(input bit v, input logic [N-1:0] d);
    adc_valid = v;
    adc_data  = d;
    @(posedge link_clk);
    model_edge();
    #1;
    check("pn_err", pn_err, m_err);
    check("pn_oos", pn_oos, m_oos);
`ifdef AD_IP_JESD204_TPL_PN_ERR_COUNT_EN
    check("pn_err_count", pn_err_count, m_cnt);
`endif
    if (pn_err === 1'b1) err_seen++;
  endtask

  // Send n correct beats of the current PN sequence and note the first tick
  // index at which pn_oos is low.
  task automatic run_pn(input int n, input logic [3:0] sel);
    event_at = -1;
    for (int i = 0; i < n; i++) begin
      tick(1, gen);
      if (event_at < 0 && pn_oos === 1'b0) event_at = i;
      gen = next_beat(gen, sel);
    end
  endtask

  initial begin
    adc_rst    = 1'b1;
    adc_valid  = 1'b0;
    adc_data   = '0;
    pn_seq_sel = 4'd0;
    err_seen   = 0;

    // Reset state
    tick(0, '0);
    tick(0, '0);
    check("reset_oos", pn_oos, 1);
    check("reset_err", pn_err, 0);
    adc_rst = 1'b0;

    // Sync acquisition on PN9: seed beat at tick 0, 16 matches, +2 latency
    gen      = $urandom | 32'h0001_0000;
    err_seen = 0;
    run_pn(20, 4'd0);
    check("pn9_acq_tick", event_at, 17);
    check("pn9_acq_no_err", err_seen, 0);

    // Single flipped bit in sync: one pulse two cycles later
    err_seen = 0;
    event_at = -1;
    tick(1, gen ^ 32'h0000_0008);
    gen = next_beat(gen, 4'd0);
    for (int i = 1; i < 8; i++) begin
      tick(1, gen);
      if (event_at < 0 && pn_err === 1'b1) event_at = i;
      gen = next_beat(gen, 4'd0);
    end
    check("single_err_tick", event_at, 1);
    check("single_err_pulses", err_seen, 1);
    check("single_err_oos", pn_oos, 0);
`ifdef AD_IP_JESD204_TPL_PN_ERR_COUNT_EN
    check("single_err_count", pn_err_count, 1);
`endif

    // Loss of sync: 16 zero beats pulse 16 times, later zeros are quiet
    err_seen = 0;
    event_at = -1;
    for (int i = 0; i < 19; i++) begin
      tick(1, '0);
      if (event_at < 0 && pn_oos === 1'b1) event_at = i;
    end
    check("loss_oos_tick", event_at, 16);
    check("loss_pulses", err_seen, 16);

    // Ramp across the 0xFFFF wrap with invalid gaps filled with garbage
    pn_seq_sel = 4'd2;
    ramp       = 16'hFFF0;
    err_seen   = 0;
    for (int v = 0; v < 16; v++) begin
      tick(1, {ramp + 16'd1, ramp});
      ramp = ramp + 16'd2;
      if (v % 2 == 0) tick(0, $urandom);
      if ($urandom_range(0, 1) == 1) tick(0, $urandom);
    end
    for (int i = 0; i < 3; i++) tick(0, $urandom);
    check("ramp_15_matches_oos", pn_oos, 1);
    tick(1, {ramp + 16'd1, ramp});
    ramp = ramp + 16'd2;
    for (int i = 0; i < 3; i++) tick(0, $urandom);
    check("ramp_16_matches_sync", pn_oos, 0);
    check("ramp_no_err", err_seen, 0);

    // PN23 acquisition
    pn_seq_sel = 4'd1;
    gen        = $urandom | 32'h0001_0000;
    err_seen   = 0;
    run_pn(20, 4'd1);
    check("pn23_acq_tick", event_at, 17);
    check("pn23_acq_no_err", err_seen, 0);

    // Bad beat then disable: in-flight pulse suppressed, OOS next cycle
    err_seen = 0;
    tick(1, gen ^ 32'h0000_0008);
    gen = next_beat(gen, 4'd1);
    pn_seq_sel = 4'hF;
    tick(1, gen);
    gen = next_beat(gen, 4'd1);
    check("off_oos", pn_oos, 1);
    check("off_err", pn_err, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1, gen);
      gen = next_beat(gen, 4'd1);
    end
    check("off_no_err", err_seen, 0);
`ifdef AD_IP_JESD204_TPL_PN_ERR_COUNT_EN
    check("off_count_cleared", pn_err_count, 0);
`endif

    // Back to PN23: seed beat plus 16 to resync
    pn_seq_sel = 4'd1;
    run_pn(20, 4'd1);
    check("pn23_resync_tick", event_at, 17);
    check("pn23_resync_no_err", err_seen, 0);

    // Reset in the middle of an error burst
    err_seen = 0;
    for (int i = 0; i < 5; i++) tick(1, '0);
    check("burst_pulses", err_seen, 4);
    adc_rst = 1'b1;
    tick(1, '0);
    adc_rst = 1'b0;
    check("midrst_oos", pn_oos, 1);
    check("midrst_err", pn_err, 0);
`ifdef AD_IP_JESD204_TPL_PN_ERR_COUNT_EN
    check("midrst_count", pn_err_count, 0);
`endif
    gen      = $urandom | 32'h0001_0000;
    err_seen = 0;
    run_pn(20, 4'd1);
    check("post_rst_acq_tick", event_at, 17);
    check("post_rst_no_err", err_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
